// File: rtl/acl_spi_responder_if.sv
// SPI bus bundle between an SPI master (accelerometer reader or bench) and
// the acl_spi_responder. sclk idles low (mode 0), csn is active-low.
interface acl_spi_responder_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output csn,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  csn,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/acl_spi_responder.sv
// ADXL362-style SPI mode-0 responder running entirely in the clk_8mhz domain.
// Bus pins are oversampled through synchronizers, so sclk must stay <= 1 MHz.
// Protocol: command byte (0x0A write / 0x0B read), address byte, data bytes
// with an auto-incrementing 8-bit address pointer.
// Optional build macro ACL_SPI_RESPONDER_SOFT_RESET_EN: address 0x1F becomes
// a write-only SOFT_RESET register; writing 0x52 clears POWER_CTL.
module acl_spi_responder #(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk_8mhz,
  input  logic                 nrst,
  acl_spi_responder_if.slave   spi,
  input  logic [11:0]          x_data,
  input  logic [11:0]          y_data,
  input  logic [11:0]          z_data,
  output logic                 measure_en
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_W, ADDR_R, DATA_WR, DATA_RD, IGNORE
  } state_e;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] ADDR_PWR_CTL  = 8'h2D;
`ifdef ACL_SPI_RESPONDER_SOFT_RESET_EN
  localparam logic [7:0] ADDR_SOFT_RST = 8'h1F;
  localparam logic [7:0] SOFT_RST_KEY  = 8'h52;
`endif

  // Synchronizer chains; the MSB is the synchronized value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q,  csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, csn_prev_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  // First seven received bits; the eighth completes rx_byte directly.
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic [15:0] snap_x_q, snap_x_d;
  logic [15:0] snap_y_q, snap_y_d;
  logic [15:0] snap_z_q, snap_z_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        measure_en_q, measure_en_d;

  logic        sclk_s, csn_s, mosi_s;
  logic        sclk_rise, sclk_fall, csn_fall, byte_done;
  logic [7:0]  rx_byte, rd_addr, rd_data;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign rx_byte   = {shift_q, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  // Shift each pin one stage deeper into its synchronizer.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0],  spi.csn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
  end

  // Register file read address: the addressed byte right after ADDR_R,
  // otherwise the next location of a burst.
  always_comb begin
    rd_addr = (state_q == ADDR_R) ? rx_byte : addr_q + 8'd1;
  end

  // Register map read mux; unmapped (and write-only) addresses read zero.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      8'h00:        rd_data = DEVID_AD;
      8'h01:        rd_data = DEVID_MST;
      8'h02:        rd_data = PARTID;
      8'h0E:        rd_data = snap_x_q[7:0];
      8'h0F:        rd_data = snap_x_q[15:8];
      8'h10:        rd_data = snap_y_q[7:0];
      8'h11:        rd_data = snap_y_q[15:8];
      8'h12:        rd_data = snap_z_q[7:0];
      8'h13:        rd_data = snap_z_q[15:8];
      ADDR_PWR_CTL: rd_data = power_ctl_q;
      default:      rd_data = 8'h00;
    endcase
  end

  // Transaction FSM, shift registers, pointer, register writes and miso.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    power_ctl_d  = power_ctl_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_z_d     = snap_z_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    measure_en_d = (power_ctl_q[1:0] == 2'b10);

    if (csn_s) begin
      // Deselected: drop any partial byte and release miso.
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else if (csn_fall) begin
      state_d   = CMD;
      bit_cnt_d = 3'd0;
      snap_x_d  = {{4{x_data[11]}}, x_data};
      snap_y_d  = {{4{y_data[11]}}, y_data};
      snap_z_d  = {{4{z_data[11]}}, z_data};
    end else begin
      if (sclk_rise) begin
        shift_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          CMD: begin
            if (rx_byte == CMD_WRITE)     state_d = ADDR_W;
            else if (rx_byte == CMD_READ) state_d = ADDR_R;
            else                          state_d = IGNORE;
          end
          ADDR_W: begin
            addr_d  = rx_byte;
            state_d = DATA_WR;
          end
          ADDR_R: begin
            addr_d  = rx_byte;
            tx_d    = rd_data;
            state_d = DATA_RD;
          end
          DATA_WR: begin
            if (addr_q == ADDR_PWR_CTL) power_ctl_d = rx_byte;
`ifdef ACL_SPI_RESPONDER_SOFT_RESET_EN
            else if (addr_q == ADDR_SOFT_RST && rx_byte == SOFT_RST_KEY)
              power_ctl_d = 8'h00;
`endif
            addr_d = addr_q + 8'd1;
          end
          DATA_RD: begin
            addr_d = addr_q + 8'd1;
            tx_d   = rd_data;
          end
          default: ;
        endcase
      end
      if (sclk_fall && state_q == DATA_RD) begin
        miso_d    = tx_q[7];
        tx_d      = {tx_q[6:0], 1'b0};
        miso_oe_d = 1'b1;
      end
    end
  end

  // State register; nrst clears everything immediately, even mid-transaction.
  always_ff @(posedge clk_8mhz or negedge nrst) begin
    if (!nrst) begin
      // NOTE: csn synchronizer resets to the idle (high) level so leaving
      // reset with the bus idle cannot fake a chip-select falling edge.
      sclk_sync_q  <= '0;
      csn_sync_q   <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      csn_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      tx_q         <= 8'h00;
      addr_q       <= 8'h00;
      power_ctl_q  <= 8'h00;
      snap_x_q     <= 16'h0000;
      snap_y_q     <= 16'h0000;
      snap_z_q     <= 16'h0000;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      measure_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      sclk_sync_q  <= sclk_sync_d;
      csn_sync_q   <= csn_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_s;
      csn_prev_q   <= csn_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      power_ctl_q  <= power_ctl_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      snap_z_q     <= snap_z_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      measure_en_q <= measure_en_d;
    end
  end

  // miso_q is only ever set together with miso_oe_q, so miso is 0 when idle.
  assign spi.miso     = miso_q;
  assign spi.miso_oe  = miso_oe_q;
  assign measure_en   = measure_en_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: a bit-banged SPI master issues
// directed and random transactions; a register-map model predicts each
// received byte into a queue that a separate miso monitor drains.
`timescale 1ns/1ps
module tb_acl_spi_responder;

  logic        clk_8mhz;
  logic        nrst;
  logic [11:0] x_data, y_data, z_data;
  logic        measure_en;

  acl_spi_responder_if bus ();

  acl_spi_responder dut (
    .clk_8mhz   (clk_8mhz),
    .nrst       (nrst),
    .spi        (bus.slave),
    .x_data     (x_data),
    .y_data     (y_data),
    .z_data     (z_data),
    .measure_en (measure_en)
  );

  initial clk_8mhz = 1'b0;
  always #62.5 clk_8mhz = ~clk_8mhz;

  typedef struct packed {
    logic       oe;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tx_bytes[$];
  int          passed = 0;
  int          total  = 0;
  int          chg_idx = -1;
  logic [11:0] chg_x;

  // Reference model state: POWER_CTL and the snapshot seen by a transaction.
  logic [7:0]  pc_m;
  logic [15:0] sx_m, sy_m, sz_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [15:0] sext(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic logic [7:0] mread(input logic [7:0] a);
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h0E: return sx_m[7:0];
      8'h0F: return sx_m[15:8];
      8'h10: return sy_m[7:0];
      8'h11: return sy_m[15:8];
      8'h12: return sz_m[7:0];
      8'h13: return sz_m[15:8];
      8'h2D: return pc_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mwrite(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h2D) pc_m = d;
`ifdef ACL_SPI_RESPONDER_SOFT_RESET_EN
    else if (a == 8'h1F && d == 8'h52) pc_m = 8'h00;
`endif
  endtask

  // One mode-0 bit at 1 MHz: data set up, rise, hold high, fall.
  task automatic send_bit(input logic b);
    bus.mosi = b;
    #250 bus.sclk = 1'b1;
    #500 bus.sclk = 1'b0;
    #250;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
  endtask

  // Runs tx_bytes as one transaction, optionally followed by a partial byte
  // and optionally a reset asserted while csn is still low.
  task automatic run_txn(input int partial_bits, input logic [7:0] partial_byte,
                         input bit do_reset);
    logic [7:0] cmd, addr;
    exp_t       e;
    cmd  = (tx_bytes.size() > 0) ? tx_bytes[0] : 8'h00;
    addr = (tx_bytes.size() > 1) ? tx_bytes[1] : 8'h00;
    sx_m = sext(x_data);
    sy_m = sext(y_data);
    sz_m = sext(z_data);
    bus.csn = 1'b0;
    #500;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      if (i >= 2 && cmd == 8'h0B) e = '{oe: 1'b1, data: mread(addr + 8'(i - 2))};
      else                        e = '{oe: 1'b0, data: 8'h00};
      exp_q.push_back(e);
      send_byte(tx_bytes[i]);
      if (i >= 2 && cmd == 8'h0A) mwrite(addr + 8'(i - 2), tx_bytes[i]);
      if (i == chg_idx) x_data = chg_x;
    end
    for (int k = 0; k < partial_bits; k++) send_bit(partial_byte[7 - k]);
    #500;
    if (do_reset) begin
      nrst = 1'b0;
      #250;
      check("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
      check("rst_miso", {31'd0, bus.miso}, 32'd0);
      check("rst_measure_en", {31'd0, measure_en}, 32'd0);
      bus.csn = 1'b1;
      #250 nrst = 1'b1;
      pc_m = 8'h00;
    end else begin
      bus.csn = 1'b1;
    end
    #1000;
    @(negedge clk_8mhz);
  endtask

  task automatic check_measure(input string name);
    check(name, {31'd0, measure_en}, {31'd0, pc_m[1:0] == 2'b10});
  endtask

  // Monitor: assemble what the master samples on each rising sclk edge and
  // compare every completed byte with the scoreboard; partial bytes drop.
  initial begin : monitor
    logic [7:0] mon_data, mon_oe;
    int         mon_cnt;
    exp_t       e;
    mon_cnt = 0;
    forever begin
      @(posedge bus.sclk or posedge bus.csn);
      if (bus.csn) begin
        mon_cnt = 0;
      end else begin
        mon_data = {mon_data[6:0], bus.miso};
        mon_oe   = {mon_oe[6:0], bus.miso_oe};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          check("sb_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_byte", {24'd0, mon_data}, {24'd0, e.data});
            check("oe_bits", {24'd0, mon_oe}, {24'd0, {8{e.oe}}});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] addr_pool [13];

  initial begin : stimulus
    int         n_data, sel;
    logic [7:0] cmd, addr, d;
    addr_pool = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h11,
                  8'h12, 8'h13, 8'h2D, 8'h1F, 8'hFE, 8'h40};
    bus.sclk = 1'b0;
    bus.csn  = 1'b1;
    bus.mosi = 1'b0;
    nrst     = 1'b0;
    x_data   = '0;
    y_data   = '0;
    z_data   = '0;
    pc_m     = 8'h00;

    #300;
    check("reset_miso", {31'd0, bus.miso}, 32'd0);
    check("reset_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
    check("reset_measure_en", {31'd0, measure_en}, 32'd0);
    @(negedge clk_8mhz) nrst = 1'b1;
    repeat (4) @(negedge clk_8mhz);

    // POWER_CTL reads zero out of reset.
    tx_bytes = '{8'h0B, 8'h2D, 8'h00};                 run_txn(0, 8'h00, 1'b0);
    // ID burst.
    tx_bytes = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};   run_txn(0, 8'h00, 1'b0);
    // Write POWER_CTL = measure, then read it back.
    tx_bytes = '{8'h0A, 8'h2D, 8'h02};                 run_txn(0, 8'h00, 1'b0);
    check_measure("measure_after_write");
    tx_bytes = '{8'h0B, 8'h2D, 8'h00};                 run_txn(0, 8'h00, 1'b0);
    // Sample burst with sign extension.
    x_data = 12'h123; y_data = 12'hF80; z_data = 12'h7FF;
    tx_bytes = '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(0, 8'h00, 1'b0);
    // Snapshot coherency: x changes after the second data byte.
    chg_idx = 3; chg_x = 12'h456;
    run_txn(0, 8'h00, 1'b0);
    chg_idx = -1;
    tx_bytes = '{8'h0B, 8'h0E, 8'h00, 8'h00};          run_txn(0, 8'h00, 1'b0);
    // Aborted write of POWER_CTL after 5 bits leaves it unchanged.
    tx_bytes = '{8'h0A, 8'h2D};                        run_txn(5, 8'hFF, 1'b0);
    check_measure("measure_after_abort");
    tx_bytes = '{8'h0B, 8'h2D, 8'h00};                 run_txn(0, 8'h00, 1'b0);
    // Unknown command: no miso, no write.
    tx_bytes = '{8'h55, 8'h2D, 8'h00, 8'h00};          run_txn(0, 8'h00, 1'b0);
    tx_bytes = '{8'h0B, 8'h2D, 8'h00};                 run_txn(0, 8'h00, 1'b0);
    // Pointer wrap 0xFF -> 0x00.
    tx_bytes = '{8'h0B, 8'hFF, 8'h00, 8'h00};          run_txn(0, 8'h00, 1'b0);
    // Soft reset key write (model decides the outcome per build).
    tx_bytes = '{8'h0A, 8'h2D, 8'h02};                 run_txn(0, 8'h00, 1'b0);
    tx_bytes = '{8'h0A, 8'h1F, 8'h52};                 run_txn(0, 8'h00, 1'b0);
    check_measure("measure_after_soft_reset");
    tx_bytes = '{8'h0B, 8'h2D, 8'h1F, 8'h00};          run_txn(0, 8'h00, 1'b0);
    // nrst during a read data phase.
    tx_bytes = '{8'h0A, 8'h2D, 8'h02};                 run_txn(0, 8'h00, 1'b0);
    tx_bytes = '{8'h0B, 8'h2D};                        run_txn(3, 8'h00, 1'b1);
    repeat (4) @(negedge clk_8mhz);
    tx_bytes = '{8'h0B, 8'h2D, 8'h00};                 run_txn(0, 8'h00, 1'b0);

    // Random transactions against the model.
    for (int t = 0; t < 30; t++) begin
      x_data = 12'($urandom);
      y_data = 12'($urandom);
      z_data = 12'($urandom);
      sel = $urandom_range(0, 3);
      if (sel <= 1)      cmd = 8'h0B;
      else if (sel == 2) cmd = 8'h0A;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h55;
      end
      addr   = addr_pool[$urandom_range(0, 12)];
      n_data = $urandom_range(0, 4);
      tx_bytes = '{cmd, addr};
      for (int i = 0; i < n_data; i++) begin
        d = 8'($urandom);
        if (cmd == 8'h0A && $urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h52 : 8'h02;
        tx_bytes.push_back(d);
      end
      run_txn(0, 8'h00, 1'b0);
      check_measure("measure_random");
    end

    #2000;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- SPI mode-0 responder that emulates the register-level ADXL362 interface: command byte, address byte, then data bytes.
- Used two ways:
  - in simulation and on a second board as the far end for the accelerometer reader;
  - as a stand-in device when the real sensor is absent.
- Runs entirely in the clk_8mhz domain and oversamples sclk/csn/mosi, so sclk is limited to 1 MHz.
- Serves fixed ID registers, a snapshot of externally supplied X/Y/Z samples, and a writable POWER_CTL register.

Parameters:
- DEVID_AD, 8'hAD, value read at address 0x00.
- DEVID_MST, 8'h1D, value read at address 0x01.
- PARTID, 8'hF2, value read at address 0x02.
- SYNC_STAGES, 2, synchronizer depth on sclk/csn/mosi (minimum 2).

Ports:
- clk_8mhz  in  1  system clock.
- nrst  in  1  reset; asynchronous, active-low.
- sclk  in  1  SPI clock from the master; asynchronous; idles low.
- csn  in  1  SPI chip select; active-low; asynchronous.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  high while the responder drives miso during a read data phase.
- x_data  in  12  signed X sample.
- y_data  in  12  signed Y sample.
- z_data  in  12  signed Z sample.
- measure_en  out  1  high when POWER_CTL[1:0]==2'b10.

Behaviour:
- Reset values: miso=0, miso_oe=0, measure_en=0, POWER_CTL=8'h00, state=IDLE, bit counter=0, snapshot registers=0.
- Synchronization:
  - sclk, csn and mosi each pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected on the synchronized value (one extra flop).
  - Response latency from a pin edge to internal action is SYNC_STAGES+1 clk_8mhz cycles, at most 375 ns at the defaults.
- Chip select:
  - Synchronized csn falling edge: bit counter=0, state=CMD, snapshot taken.
  - Synchronized csn high at any time, including mid-byte: state=IDLE, miso_oe=0, partial byte discarded, no register write.
- Sampling and driving:
  - mosi is sampled on sclk rising edges, MSB first, into an 8-bit shift register; a 3-bit counter wraps 7->0.
  - miso changes only on sclk falling edges; miso=0 whenever miso_oe=0.
- Snapshot:
  - On csn fall, x/y/z are each sign-extended 12->16 bits and registered.
  - All reads of 0x0E..0x13 in that transaction return the snapshot, so a burst is coherent.
- State machine:
  - IDLE -> CMD on csn fall.
  - CMD, on the 8th rising edge:
    - byte 8'h0A -> ADDR_W;
    - byte 8'h0B -> ADDR_R;
    - any other byte -> IGNORE.
  - ADDR_W, on the 8th rising edge: address pointer=byte, next state DATA_WR.
  - ADDR_R, on the 8th rising edge: address pointer=byte, read byte loaded into the transmit shift register, next state DATA_RD.
    - Bit 7 is driven and miso_oe=1 at the next sclk falling edge.
  - DATA_WR, on each 8th rising edge: write byte to the pointer address, pointer+1.
  - DATA_RD:
    - each sclk falling edge shifts the next bit out;
    - on each 8th rising edge pointer+1 and the next byte is loaded;
    - that byte's bit 7 is driven at the following falling edge.
  - IGNORE: no writes, miso_oe=0, until csn rises.
- Address pointer is 8 bits and wraps 0xFF->0x00.
- Register map, reads:
  - 0x00 DEVID_AD; 0x01 DEVID_MST; 0x02 PARTID.
  - 0x0E X[7:0]; 0x0F X[15:8]; 0x10 Y[7:0]; 0x11 Y[15:8]; 0x12 Z[7:0]; 0x13 Z[15:8].
  - 0x2D POWER_CTL.
  - All other addresses read 8'h00.
- Register map, writes: only 0x2D is writable; writes to any other address are ignored.
- measure_en updates on the clk_8mhz cycle after a POWER_CTL write.
- nrst asserted mid-transaction returns everything to reset values immediately.

Optional Feature:
- Macro: ACL_SPI_RESPONDER_SOFT_RESET_EN.
- Defined:
  - Address 0x1F is SOFT_RESET, write-only; it reads 8'h00.
  - Writing 8'h52 clears POWER_CTL to 8'h00 (so measure_en=0) and the current transaction continues normally.
  - Writing any other value has no effect.
- Undefined: 0x1F behaves as an unmapped address.

Test Plan:
- ID burst: csn low, mosi bytes 0B 00 then 3 dummy bytes -> miso returns AD 1D F2; miso_oe=1 only during those 3 bytes.
- Write then read: 0A 2D 02 -> measure_en=1 within 2 cycles of the 8th rising edge; then 0B 2D xx -> 02.
- Sample burst: x=12'h123, y=12'hF80, z=12'h7FF; command 0B 0E plus 6 dummy bytes -> 23 01 80 FF FF 07.
- Snapshot coherency: same burst with x changed to 12'h456 after the 2nd data byte -> X bytes still 23 01; the next transaction returns 56 04.
- Abort and unknown command:
  - csn raised after 5 bits of a POWER_CTL data byte (0A 2D, then 5 bits of 02) -> POWER_CTL unchanged.
  - Command 55 -> miso_oe stays 0 and no state change.
- Soft reset, with the macro defined: POWER_CTL=02, then write 0A 1F 52 -> measure_en=0 and a read of 0x2D returns 00. Without the macro the same write leaves POWER_CTL=02.
